// File: rtl/kbd_pkg.sv
// Shared constants for the keyboard interrupt FIFO: bus map, IRQ vector,
// IRQ FSM state encoding and status-register bit layout.
package kbd_pkg;

  // Bus map
  localparam logic [63:0] KEY_ADDR  = 64'h8000_0010;
  localparam logic [63:0] STAT_ADDR = 64'h8000_0018;

  // Vector presented to the CPU while keys are pending
  localparam logic [3:0] IRQ_VEC_KEYBOARD = 4'd1;

  // IRQ FSM state encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PEND = 2'd1;
  localparam logic [1:0] ST_ACK  = 2'd2;

  // Status register layout
  localparam int unsigned STAT_EMPTY_BIT = 0;
  localparam int unsigned STAT_FULL_BIT  = 1;
  localparam int unsigned STAT_OVF_BIT   = 2;
  localparam int unsigned STAT_COUNT_LSB = 8;

  // Data register layout
  localparam int unsigned DATA_VALID_BIT = 8;

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO. A push while full is accepted when a pop
// happens on the same edge; a pop while empty is ignored.
module sync_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign empty     = (r_count == '0);
  assign full      = (r_count == (AW+1)'(DEPTH));
  assign w_do_pop  = pop & ~empty;
  assign w_do_push = push & (~full | w_do_pop);
  assign dout      = r_mem[r_rptr];
  assign count     = r_count;

  // Storage write; contents need no reset since occupancy gates visibility
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wptr] <= din;
    end
  end

  // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + AW'(1);
      if (w_do_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/kbd_irq_fifo.sv
// Keyboard capture FIFO with bus-readable data/status registers and an
// interrupt handshake that guarantees a vector low gap between services.
module kbd_irq_fifo #(
  parameter int unsigned  DEPTH     = 8,
  parameter logic [63:0]  KEY_ADDR  = kbd_pkg::KEY_ADDR,
  parameter logic [63:0]  STAT_ADDR = kbd_pkg::STAT_ADDR,
  parameter logic [3:0]   IRQ_VEC   = kbd_pkg::IRQ_VEC_KEYBOARD
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [7:0]              key_code,
  input  logic                    key_pressed,
  input  logic [63:0]             bus_address,
  input  logic                    bus_read_enable,
  output logic [63:0]             bus_read_data,
  output logic [3:0]              interrupt_vector,
  input  logic                    interrupt_done,
  output logic [$clog2(DEPTH):0]  fifo_count,
  output logic                    overflow
);

  import kbd_pkg::*;

  logic        r_kp;
  logic        r_armed;
  logic        r_overflow;
  logic [1:0]  r_state;
  logic [3:0]  r_vec;
  logic [1:0]  w_next;
  logic        w_push;
  logic        w_pop;
  logic        w_drop;
  logic        w_key_hit;
  logic        w_stat_hit;
  logic        w_full;
  logic        w_empty;
  logic [7:0]  w_dout;
  logic [63:0] w_rdata;
  logic [$clog2(DEPTH):0] w_count;

  // r_armed stays low for the first cycle after reset release so that a key
  // held through reset is seen as already pressed rather than as a new edge.
  assign w_push     = r_armed & key_pressed & ~r_kp;
  assign w_key_hit  = (bus_address == KEY_ADDR);
  assign w_stat_hit = (bus_address == STAT_ADDR);
  assign w_pop      = bus_read_enable & w_key_hit;
  assign w_drop     = w_push & w_full & ~(w_pop & ~w_empty);

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .push  (w_push),
    .pop   (w_pop),
    .din   (key_code),
    .dout  (w_dout),
    .count (w_count),
    .full  (w_full),
    .empty (w_empty)
  );

  // Key-press edge detector state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_kp    <= 1'b0;
      r_armed <= 1'b0;
    end else begin
      r_kp    <= key_pressed;
      r_armed <= 1'b1;
    end
  end

  // Sticky overflow; a fresh drop wins over a status-read clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (bus_read_enable && w_stat_hit) begin
      r_overflow <= 1'b0;
    end
  end

  // Bus read mux: data register, status register, or zero
  always_comb begin
    w_rdata = '0;
    if (w_key_hit) begin
      if (!w_empty) begin
        w_rdata[7:0]          = w_dout;
        w_rdata[DATA_VALID_BIT] = 1'b1;
      end
    end else if (w_stat_hit) begin
      w_rdata[STAT_COUNT_LSB +: 8] = 8'(w_count);
      w_rdata[STAT_OVF_BIT]        = r_overflow;
      w_rdata[STAT_FULL_BIT]       = w_full;
      w_rdata[STAT_EMPTY_BIT]      = w_empty;
    end
  end

  // IRQ next state. ACK resolves the IDLE decision in the same step so the
  // vector is low for exactly the one ACK cycle when keys are still pending.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_count != '0) w_next = ST_PEND;
      ST_PEND: if (interrupt_done) w_next = ST_ACK;
      ST_ACK:  w_next = (w_count != '0) ? ST_PEND : ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // IRQ state and registered vector output
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_vec   <= '0;
    end else begin
      r_state <= w_next;
      r_vec   <= (w_next == ST_PEND) ? IRQ_VEC : '0;
    end
  end

  assign bus_read_data    = w_rdata;
  assign interrupt_vector = r_vec;
  assign fifo_count       = w_count;
  assign overflow         = r_overflow;

endmodule

// File: tb/tb_kbd_irq_fifo.sv
// Bench for kbd_irq_fifo: directed scenarios plus random traffic, all
// compared against a queue-based reference model.
module tb_kbd_irq_fifo;

  localparam int          DEPTH = 8;
  localparam logic [63:0] KEY   = 64'h8000_0010;
  localparam logic [63:0] STAT  = 64'h8000_0018;
  localparam logic [63:0] OTHER = 64'h8000_0020;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  key_code;
  logic        key_pressed;
  logic [63:0] bus_address;
  logic        bus_read_enable;
  logic [63:0] bus_read_data;
  logic [3:0]  interrupt_vector;
  logic        interrupt_done;
  logic [3:0]  fifo_count;
  logic        overflow;

  int n_chk = 0;
  int n_err = 0;

  kbd_irq_fifo #(
    .DEPTH     (DEPTH),
    .KEY_ADDR  (KEY),
    .STAT_ADDR (STAT),
    .IRQ_VEC   (4'd1)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .key_code         (key_code),
    .key_pressed      (key_pressed),
    .bus_address      (bus_address),
    .bus_read_enable  (bus_read_enable),
    .bus_read_data    (bus_read_data),
    .interrupt_vector (interrupt_vector),
    .interrupt_done   (interrupt_done),
    .fifo_count       (fifo_count),
    .overflow         (overflow)
  );

  always #5 clk = ~clk;

  // Reference model: pending keys as a queue, plus flags
  logic [7:0] m_q[$];
  bit         m_ovf, m_irq, m_prev_kp, m_armed;
  int         m_sz;
  bit         m_push, m_pop;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_q.delete();
      m_ovf = 0; m_irq = 0; m_prev_kp = 0; m_armed = 0;
    end else begin
      m_sz   = m_q.size();
      m_push = m_armed && key_pressed && !m_prev_kp;
      m_pop  = bus_read_enable && bus_address == KEY && m_sz > 0;
      // vector: raised when anything was pending, dropped for one cycle on done
      if (m_irq) m_irq = !interrupt_done;
      else       m_irq = (m_sz > 0);
      if (bus_read_enable && bus_address == STAT) m_ovf = 0;
      if (m_pop) void'(m_q.pop_front());
      if (m_push) begin
        if (m_sz < DEPTH || m_pop) m_q.push_back(key_code);
        else m_ovf = 1;
      end
      m_prev_kp = key_pressed;
      m_armed   = 1;
    end
  end

  function automatic logic [63:0] exp_rd();
    logic [63:0] r = '0;
    if (bus_address == KEY) begin
      if (m_q.size() > 0) r = {55'd0, 1'b1, m_q[0]};
    end else if (bus_address == STAT) begin
      r = {48'd0, 8'(m_q.size()), 5'd0, m_ovf, m_q.size() == DEPTH, m_q.size() == 0};
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Apply inputs (just after a falling edge) and check the combinational read path
  task automatic drive(input logic kp, input logic [7:0] code, input logic rd,
                       input logic [63:0] addr, input logic done);
    key_pressed = kp; key_code = code; bus_read_enable = rd;
    bus_address = addr; interrupt_done = done;
    #1;
    chk("rdata", bus_read_data, exp_rd());
  endtask

  // Advance one clock and check registered outputs against the model
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    chk("count", 64'(fifo_count), 64'(m_q.size()));
    chk("ovf", 64'(overflow), 64'(m_ovf));
    chk("vec", 64'(interrupt_vector), m_irq ? 64'd1 : 64'd0);
  endtask

  task automatic idle();
    drive(0, 8'h00, 0, OTHER, 0);
  endtask

  task automatic press(input logic [7:0] code);
    drive(1, code, 0, OTHER, 0); tick();
    drive(0, code, 0, OTHER, 0); tick();
  endtask

  task automatic rd_key(input logic [63:0] exp);
    drive(0, 8'h00, 1, KEY, 0);
    chk("keyread", bus_read_data, exp);
    tick();
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 1; i++) begin
      if (m_q.size() > 0) begin drive(0, 8'h00, 1, KEY, 0); tick(); end
    end
    idle(); tick();
  endtask

  logic [7:0] keys [9];

  initial begin
    reset = 1'b0;
    key_pressed = 0; key_code = 0; bus_address = OTHER;
    bus_read_enable = 0; interrupt_done = 0;
    #12;
    chk("rst_count", 64'(fifo_count), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    chk("rst_vec", 64'(interrupt_vector), 64'd0);
    @(negedge clk); reset = 1'b1;
    idle(); tick(); tick();

    // 1: single key, latency of count and vector, then pop
    drive(1, 8'h41, 0, OTHER, 0); tick();
    chk("t1_count", 64'(fifo_count), 64'd1);
    drive(0, 8'h41, 0, OTHER, 0); tick();
    chk("t1_vec", 64'(interrupt_vector), 64'd1);
    rd_key(64'h141);
    chk("t1_count0", 64'(fifo_count), 64'd0);
    drive(0, 8'h00, 0, OTHER, 1); tick(); idle(); tick(); tick();

    // 2: ordered reads, then empty read
    press(8'h48); press(8'h49); press(8'h21);
    rd_key(64'h148); rd_key(64'h149); rd_key(64'h121); rd_key(64'h0);
    chk("t2_count", 64'(fifo_count), 64'd0);
    drive(0, 8'h00, 0, OTHER, 1); tick(); idle(); tick();

    // 3: overflow with nine presses
    for (int i = 0; i < 9; i++) begin
      keys[i] = 8'($urandom_range(32, 126));
      press(keys[i]);
    end
    chk("t3_count", 64'(fifo_count), 64'd8);
    chk("t3_ovf", 64'(overflow), 64'd1);
    drive(0, 8'h00, 1, STAT, 0);
    chk("t3_stat", bus_read_data, 64'h0806);
    tick();
    chk("t3_ovf_clr", 64'(overflow), 64'd0);
    for (int i = 0; i < 8; i++) rd_key({55'd0, 1'b1, keys[i]});
    idle(); tick();

    // 4: full, push and pop together
    for (int i = 0; i < 8; i++) begin
      keys[i] = 8'(8'h61 + i);
      press(keys[i]);
    end
    drive(1, 8'h7a, 1, KEY, 0); tick();
    chk("t4_count", 64'(fifo_count), 64'd8);
    chk("t4_ovf", 64'(overflow), 64'd0);
    for (int i = 1; i < 8; i++) rd_key({55'd0, 1'b1, keys[i]});
    rd_key(64'h17a);
    drive(0, 8'h00, 0, OTHER, 1); tick(); idle(); tick(); tick();

    // 5: ACK gap of exactly one cycle, then silence once drained
    press(8'h31); press(8'h32);
    chk("t5_vec", 64'(interrupt_vector), 64'd1);
    drive(0, 8'h00, 0, OTHER, 1); tick();
    chk("t5_gap", 64'(interrupt_vector), 64'd0);
    idle(); tick();
    chk("t5_reassert", 64'(interrupt_vector), 64'd1);
    rd_key(64'h131); rd_key(64'h132);
    drive(0, 8'h00, 0, OTHER, 1); tick();
    idle(); tick(); tick(); tick();
    chk("t5_quiet", 64'(interrupt_vector), 64'd0);

    // 6a: key held through reset release does not push
    drive(1, 8'h55, 0, OTHER, 0);
    reset = 1'b0; tick();
    reset = 1'b1; tick(); tick(); tick();
    chk("t6_held", 64'(fifo_count), 64'd0);
    idle(); tick();
    // 6b: reset while pending with three entries
    press(8'h01); press(8'h02); press(8'h03); tick();
    chk("t6_pend", 64'(interrupt_vector), 64'd1);
    #2 reset = 1'b0;
    #1;
    chk("t6_vec_async", 64'(interrupt_vector), 64'd0);
    chk("t6_cnt_async", 64'(fifo_count), 64'd0);
    @(negedge clk); reset = 1'b1;
    idle(); tick();
    press(8'h44);
    rd_key(64'h144);
    drive(0, 8'h00, 0, OTHER, 1); tick(); idle(); tick();

    // Random traffic against the model
    for (int i = 0; i < 800; i++) begin
      logic [63:0] a;
      case ($urandom_range(0, 3))
        0, 1:    a = KEY;
        2:       a = STAT;
        default: a = {$urandom, $urandom};
      endcase
      drive(($urandom_range(0, 99) < 45) ? 1'b1 : 1'b0, 8'($urandom),
            ($urandom_range(0, 99) < 25) ? 1'b1 : 1'b0, a,
            ($urandom_range(0, 99) < 12) ? 1'b1 : 1'b0);
      tick();
    end
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
